// File: rtl/tetris_game_ctrl.sv
// Tetris game-flow sequencer: spawn, gravity-timed fall, lock, bottom-first
// line clearing, BCD scoring and game-over, all in the single clk domain.
module tetris_game_ctrl #(
    parameter int DROP_DIV = 50_000_000,
    parameter int ROWS     = 20,
    parameter int ROW_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       sel,
    input  logic             piece_stop,
    input  logic [ROWS-1:0]  row_full,
    input  logic             top_occupied,
    output logic             spawn,
    output logic             fall_tick,
    output logic             move_en,
    output logic             lock_we,
    output logic             clear_we,
    output logic [ROW_W-1:0] clear_row,
    output logic             field_clr,
    output logic [15:0]      dis_score,
    output logic             gameover,
    output logic [2:0]       state
);

    localparam int CNT_W = (DROP_DIV > 1) ? $clog2(DROP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DROP_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_FALL  = 3'd2,
        S_LOCK  = 3'd3,
        S_CHECK = 3'd4,
        S_SHIFT = 3'd5,
        S_SCORE = 3'd6,
        S_OVER  = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       lines_q, lines_d;
    logic [15:0]      score_q, score_d;
    logic [ROW_W-1:0] clear_row_q, clear_row_d;
    logic             spawn_q, spawn_d;
    logic             fall_tick_q, fall_tick_d;
    logic             move_en_q, move_en_d;
    logic             lock_we_q, lock_we_d;
    logic             clear_we_q, clear_we_d;
    logic             field_clr_q, field_clr_d;
    logic             gameover_q, gameover_d;
    logic             tick_ev;

    // Bottom-most full row: the highest set index wins.
    function automatic logic [ROW_W-1:0] highest_set(input logic [ROWS-1:0] v);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (v[i]) r = ROW_W'(i);
        end
        return r;
    endfunction

    // Points awarded for the number of lines cleared by one piece.
    function automatic logic [3:0] line_points(input logic [2:0] n);
        logic [3:0] p;
        case (n)
            3'd0:    p = 4'd0;
            3'd1:    p = 4'd1;
            3'd2:    p = 4'd3;
            3'd3:    p = 4'd5;
            default: p = 4'd8;
        endcase
        return p;
    endfunction

    // Four-digit BCD add of a small value; overflow past 9999 pins at 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [3:0] b);
        logic [15:0] r;
        logic [4:0]  d;
        logic        carry;
        r     = '0;
        carry = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d = {1'b0, a[4*k +: 4]} + {1'b0, (k == 0) ? b : 4'd0} + {4'd0, carry};
            if (d > 5'd9) begin
                d     = d - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            r[4*k +: 4] = d[3:0];
        end
        if (carry) r = 16'h9999;
        return r;
    endfunction

    // Next-state and registered-output decode. Pulses are computed on the
    // transition so they are high during the cycle of the state that owns them.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lines_d     = lines_q;
        score_d     = score_q;
        clear_row_d = clear_row_q;
        spawn_d     = 1'b0;
        fall_tick_d = 1'b0;
        lock_we_d   = 1'b0;
        clear_we_d  = 1'b0;
        field_clr_d = 1'b0;
        tick_ev     = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    field_clr_d = 1'b1;
                    score_d     = '0;
                    state_d     = S_SPAWN;
                end
            end
            S_SPAWN: begin
                if (top_occupied) begin
                    state_d = S_OVER;
                end else begin
                    spawn_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_FALL;
                end
            end
            S_FALL: begin
                if (sel == 2'b11 || cnt_q == CNT_LAST) begin
                    tick_ev = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (tick_ev) begin
                    if (piece_stop) begin
                        lock_we_d = 1'b1;
                        state_d   = S_LOCK;
                    end else begin
                        fall_tick_d = 1'b1;
                    end
                end
            end
            S_LOCK: begin
                lines_d = '0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (|row_full) begin
                    clear_row_d = highest_set(row_full);
                    clear_we_d  = 1'b1;
                    if (lines_q < 3'd4) lines_d = lines_q + 1'b1;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_SCORE;
                end
            end
            S_SHIFT: begin
                state_d = S_CHECK;
            end
            S_SCORE: begin
                score_d = bcd_add_sat(score_q, line_points(lines_q));
                state_d = S_SPAWN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        move_en_d  = (state_d == S_FALL);
        gameover_d = (state_d == S_OVER);
    end

    // State, counters, score and every output register; reset returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lines_q     <= '0;
            score_q     <= '0;
            clear_row_q <= '0;
            spawn_q     <= 1'b0;
            fall_tick_q <= 1'b0;
            move_en_q   <= 1'b0;
            lock_we_q   <= 1'b0;
            clear_we_q  <= 1'b0;
            field_clr_q <= 1'b0;
            gameover_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lines_q     <= lines_d;
            score_q     <= score_d;
            clear_row_q <= clear_row_d;
            spawn_q     <= spawn_d;
            fall_tick_q <= fall_tick_d;
            move_en_q   <= move_en_d;
            lock_we_q   <= lock_we_d;
            clear_we_q  <= clear_we_d;
            field_clr_q <= field_clr_d;
            gameover_q  <= gameover_d;
        end
    end

    assign spawn     = spawn_q;
    assign fall_tick = fall_tick_q;
    assign move_en   = move_en_q;
    assign lock_we   = lock_we_q;
    assign clear_we  = clear_we_q;
    assign clear_row = clear_row_q;
    assign field_clr = field_clr_q;
    assign dis_score = score_q;
    assign gameover  = gameover_q;
    assign state     = state_q;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Directed bench for tetris_game_ctrl with a small playfield row model.
module tb_tetris_game_ctrl;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SPAWN = 3'd1;
    localparam logic [2:0] ST_FALL  = 3'd2;
    localparam logic [2:0] ST_LOCK  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_SHIFT = 3'd5;
    localparam logic [2:0] ST_SCORE = 3'd6;
    localparam logic [2:0] ST_OVER  = 3'd7;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  sel;
    logic        piece_stop;
    logic [19:0] row_full;
    logic        top_occupied;
    logic        spawn;
    logic        fall_tick;
    logic        move_en;
    logic        lock_we;
    logic        clear_we;
    logic [4:0]  clear_row;
    logic        field_clr;
    logic [15:0] dis_score;
    logic        gameover;
    logic [2:0]  state;

    int total;
    int bad;
    int score_m;

    tetris_game_ctrl #(.DROP_DIV(8), .ROWS(20), .ROW_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .piece_stop(piece_stop),
        .row_full(row_full), .top_occupied(top_occupied), .spawn(spawn),
        .fall_tick(fall_tick), .move_en(move_en), .lock_we(lock_we),
        .clear_we(clear_we), .clear_row(clear_row), .field_clr(field_clr),
        .dis_score(dis_score), .gameover(gameover), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    function automatic int pts(input int n);
        case (n)
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 5;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] bottom_row(input logic [19:0] v);
        for (int i = 19; i >= 0; i--) begin
            if (v[i]) return 32'(i);
        end
        return 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n;
        n = 0;
        while (state !== s && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    // Memory model: deleting row r moves every row above it down by one.
    task automatic apply_shift(input int r);
        for (int j = r; j > 0; j--) row_full[j] = row_full[j-1];
        row_full[0] = 1'b0;
    endtask

    task automatic play_round(input int nl, input string tag);
        int nclr;
        int n;
        int pend_row;
        bit pend;
        logic [31:0] exp_row;
        wait_state(ST_FALL, {tag, "_fall"});
        sel = 2'b11;
        piece_stop = 1'b1;
        step();
        chk({tag, "_lock_we"}, 32'(lock_we), 32'd1);
        sel = 2'b00;
        piece_stop = 1'b0;
        row_full = '0;
        for (int i = 0; i < nl; i++) row_full[19-i] = 1'b1;
        nclr = 0;
        n = 0;
        pend = 1'b0;
        pend_row = 0;
        while (n < 60) begin
            step();
            n++;
            if (pend) begin
                apply_shift(pend_row);
                pend = 1'b0;
            end
            if (clear_we === 1'b1) begin
                exp_row = bottom_row(row_full);
                chk({tag, "_clear_row"}, 32'(clear_row), exp_row);
                nclr++;
                pend = 1'b1;
                pend_row = int'(exp_row);
            end
            if (state === ST_SPAWN) break;
        end
        chk({tag, "_spawn_reached"}, 32'(state), 32'(ST_SPAWN));
        chk({tag, "_nclear"}, 32'(nclr), 32'(nl));
        score_m = score_m + pts(nl);
        if (score_m > 9999) score_m = 9999;
        chk({tag, "_score"}, 32'(dis_score), 32'(to_bcd(score_m)));
    endtask

    initial begin
        total = 0;
        bad = 0;
        score_m = 0;
        rst = 1'b0;
        start = 1'b0;
        sel = 2'b00;
        piece_stop = 1'b0;
        row_full = '0;
        top_occupied = 1'b0;

        step();
        step();
        chk("rst_state", 32'(state), 32'(ST_IDLE));
        chk("rst_spawn", 32'(spawn), 32'd0);
        chk("rst_fall_tick", 32'(fall_tick), 32'd0);
        chk("rst_move_en", 32'(move_en), 32'd0);
        chk("rst_lock_we", 32'(lock_we), 32'd0);
        chk("rst_clear_we", 32'(clear_we), 32'd0);
        chk("rst_clear_row", 32'(clear_row), 32'd0);
        chk("rst_field_clr", 32'(field_clr), 32'd0);
        chk("rst_score", 32'(dis_score), 32'd0);
        chk("rst_gameover", 32'(gameover), 32'd0);

        rst = 1'b1;
        step();
        chk("idle_hold", 32'(state), 32'(ST_IDLE));
        start = 1'b1;
        step();
        chk("start_field_clr", 32'(field_clr), 32'd1);
        chk("start_state", 32'(state), 32'(ST_SPAWN));
        start = 1'b0;
        step();
        chk("spawn_pulse", 32'(spawn), 32'd1);
        chk("spawn_state", 32'(state), 32'(ST_FALL));
        chk("spawn_move_en", 32'(move_en), 32'd1);
        chk("spawn_field_clr_gone", 32'(field_clr), 32'd0);

        // Gravity: one fall_tick every 8 cycles; start is ignored in FALL.
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                chk("start_ignored_state", 32'(state), 32'(ST_FALL));
                chk("start_ignored_clr", 32'(field_clr), 32'd0);
                start = 1'b0;
            end
            chk("grav1_tick", 32'(fall_tick), (k == 8) ? 32'd1 : 32'd0);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("grav2_tick", 32'(fall_tick), (k == 8) ? 32'd1 : 32'd0);
        end
        chk("grav_move_en", 32'(move_en), 32'd1);

        // Soft drop: a tick on each cycle sel=11 is held, counter restarts.
        sel = 2'b11;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("soft_tick", 32'(fall_tick), 32'd1);
        end
        sel = 2'b00;
        step();
        chk("soft_after", 32'(fall_tick), 32'd0);
        piece_stop = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("stop_no_tick", 32'(fall_tick), 32'd0);
            chk("stop_ignored", 32'(state), 32'(ST_FALL));
        end
        step();
        chk("lock_state", 32'(state), 32'(ST_LOCK));
        chk("lock_we", 32'(lock_we), 32'd1);
        chk("lock_no_tick", 32'(fall_tick), 32'd0);
        chk("lock_move_en", 32'(move_en), 32'd0);
        piece_stop = 1'b0;
        row_full = 20'h80000;
        step();
        chk("check_state", 32'(state), 32'(ST_CHECK));
        chk("lock_we_gone", 32'(lock_we), 32'd0);
        step();
        chk("clr1_we", 32'(clear_we), 32'd1);
        chk("clr1_row", 32'(clear_row), 32'd19);
        chk("clr1_state", 32'(state), 32'(ST_SHIFT));
        step();
        row_full = '0;
        chk("clr1_we_gone", 32'(clear_we), 32'd0);
        step();
        chk("score_state", 32'(state), 32'(ST_SCORE));
        step();
        chk("score1", 32'(dis_score), 32'h0001);
        chk("score1_state", 32'(state), 32'(ST_SPAWN));
        score_m = 1;
        step();
        chk("respawn", 32'(spawn), 32'd1);

        // Build the score up to 0995, then a four-line clear.
        for (int r = 0; r < 124; r++) play_round(4, "quadA");
        play_round(1, "single1");
        play_round(1, "single2");
        chk("pre_0995", 32'(dis_score), 32'h0995);
        play_round(4, "quad_1003");
        chk("score_1003", 32'(dis_score), 32'h1003);

        // Build to 9998, then a two-line clear saturates.
        for (int r = 0; r < 1124; r++) play_round(4, "quadB");
        play_round(2, "double_9998");
        chk("pre_9998", 32'(dis_score), 32'h9998);
        play_round(2, "double_sat");
        chk("score_sat", 32'(dis_score), 32'h9999);

        // Blocked spawn -> OVER, then restart.
        top_occupied = 1'b1;
        step();
        chk("over_state", 32'(state), 32'(ST_OVER));
        chk("over_no_spawn", 32'(spawn), 32'd0);
        chk("over_gameover", 32'(gameover), 32'd1);
        chk("over_move_en", 32'(move_en), 32'd0);
        step();
        chk("over_hold", 32'(state), 32'(ST_OVER));
        chk("over_score_held", 32'(dis_score), 32'h9999);
        start = 1'b1;
        step();
        chk("restart_field_clr", 32'(field_clr), 32'd1);
        chk("restart_score", 32'(dis_score), 32'h0000);
        chk("restart_state", 32'(state), 32'(ST_SPAWN));
        chk("restart_gameover", 32'(gameover), 32'd0);
        start = 1'b0;
        top_occupied = 1'b0;
        step();
        chk("restart_spawn", 32'(spawn), 32'd1);

        // Reset during SHIFT clears everything immediately.
        sel = 2'b11;
        piece_stop = 1'b1;
        step();
        chk("r_lock", 32'(state), 32'(ST_LOCK));
        sel = 2'b00;
        piece_stop = 1'b0;
        row_full = 20'h80000;
        step();
        step();
        chk("r_shift_state", 32'(state), 32'(ST_SHIFT));
        chk("r_shift_we", 32'(clear_we), 32'd1);
        rst = 1'b0;
        #1;
        chk("r_state", 32'(state), 32'(ST_IDLE));
        chk("r_clear_we", 32'(clear_we), 32'd0);
        chk("r_clear_row", 32'(clear_row), 32'd0);
        chk("r_move_en", 32'(move_en), 32'd0);
        chk("r_gameover", 32'(gameover), 32'd0);
        chk("r_score", 32'(dis_score), 32'd0);
        step();
        rst = 1'b1;
        row_full = '0;
        step();
        chk("r_post_state", 32'(state), 32'(ST_IDLE));
        chk("r_post_clear_we", 32'(clear_we), 32'd0);
        chk("r_post_spawn", 32'(spawn), 32'd0);
        chk("r_post_field_clr", 32'(field_clr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tetris_game_ctrl.md
Name: tetris_game_ctrl

Overview:
Game-flow sequencer for the Tetris playfield datapath. It owns the piece life cycle: spawn, gravity-timed fall, lock into playfield memory, and row-by-row line clearing. It also keeps the BCD score and the game-over condition. It sits between the keypad/`sel` decode and the playfield memory/move_control logic. It replaces the free-running 1 Hz clock mux with clock-enable pulses in the single `clk` domain.

Parameters:
DROP_DIV, 50_000_000, clk cycles per gravity tick (1 Hz at 50 MHz)
ROWS, 20, playfield rows; row 0 = top, row ROWS-1 = bottom
ROW_W, 5, width of row index (ceil(log2(ROWS)))

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  start/restart request, level sampled on clk
sel  in  2  move command; 2'b11 = soft drop, others passed through to mover
piece_stop  in  1  falling piece cannot move down (from move_control)
row_full  in  ROWS  per-row full flags from playfield memory
top_occupied  in  1  any cell of row 0 occupied
spawn  out  1  one-cycle pulse: load new piece coordinates
fall_tick  out  1  one-cycle pulse: move piece down one row
move_en  out  1  lateral/rotate moves permitted
lock_we  out  1  one-cycle pulse: write falling piece into memory
clear_we  out  1  one-cycle pulse: delete clear_row, shift rows above down
clear_row  out  ROW_W  row index to delete, valid with clear_we
field_clr  out  1  one-cycle pulse: zero whole playfield
dis_score  out  16  score, 4 BCD digits [15:12]=thousands
gameover  out  1  high while in OVER
state  out  3  current state encoding (debug)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, drop counter=0, lines counter=0, dis_score=0.
  - All pulse outputs are 0; move_en=0; gameover=0; clear_row=0.
- All outputs are registered. Pulses last exactly one clk cycle.
- States and encodings: IDLE=0, SPAWN=1, FALL=2, LOCK=3, CHECK=4, SHIFT=5, SCORE=6, OVER=7.
- IDLE:
  - On start=1: assert field_clr, clear dis_score, go to SPAWN.
- SPAWN (1 cycle):
  - If top_occupied=1: go to OVER, with no spawn pulse.
  - Else: assert spawn, set drop counter=0, go to FALL.
- FALL:
  - move_en=1. Drop counter increments each cycle.
  - At DROP_DIV-1 the counter wraps to 0 and a tick event occurs.
  - sel=2'b11 also causes a tick event and resets the counter to 0.
  - On a tick event with piece_stop=0: assert fall_tick and stay in FALL.
  - On a tick event with piece_stop=1: go to LOCK, with no fall_tick.
  - Without a tick event, piece_stop is ignored.
- LOCK (1 cycle): move_en=0, assert lock_we, lines counter=0, go to CHECK.
- CHECK: row_full reflects memory state from the previous cycle.
  - If row_full != 0: clear_row = highest set index (bottom-most), assert clear_we, increment lines counter (saturates at 4), go to SHIFT.
  - Else: go to SCORE.
- SHIFT (1 cycle settle for the shifted memory): go to CHECK.
- SCORE (1 cycle):
  - Add points by lines counter: 0→0, 1→1, 2→3, 3→5, 4→8.
  - BCD addition with per-digit carry. Saturates at 16'h9999.
  - Then go to SPAWN.
- OVER:
  - gameover=1; dis_score is held.
  - On start=1: assert field_clr, dis_score=0, go to SPAWN.
- start is ignored in all states except IDLE and OVER.
- sel values other than 11 have no effect in this block.
- Clearing a row never changes the index of rows below it. Scanning bottom-first with re-check after each shift is therefore correct for non-adjacent full rows.
- Reset asserted mid-clear or mid-fall: immediate return to IDLE; no pending pulse completes after release.

Test Plan:
- DROP_DIV=8, reset, start pulse → field_clr at cycle 1, then spawn next; fall_tick every 8 cycles while piece_stop=0; move_en=1.
- In FALL hold sel=2'b11 for 3 cycles → fall_tick on each of those cycles, counter restarts; piece_stop=1 during a tick → lock_we next cycle, no fall_tick.
- After lock, row_full=20'h80000 then 0 after one clear_we → clear_row=19; score +1; dis_score=16'h0001; spawn follows.
- row_full bits 19,18,17,16 set, bench model clears one bit per clear_we → four clear_we pulses with clear_row=19 each; score +8; preload 16'h0995 → 16'h1003.
- Score at 16'h9998 plus a 2-line clear → dis_score saturates at 16'h9999.
- top_occupied=1 when entering SPAWN → OVER, gameover=1, no spawn pulse; start → field_clr, dis_score=0, SPAWN; rst low during SHIFT → IDLE with all outputs 0 at once.
